// File: rtl/ifstage_fetch.sv
// Instruction-fetch stage: PC register, next-PC mux with branch adder, and a
// request/acknowledge read of a variable-latency instruction memory into the IR.
module ifstage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Fetch_req,
    input  logic        PC_LdEn,
    input  logic        PC_sel,
    input  logic [31:0] Immed,
    input  logic [31:0] Mem_data,
    input  logic        Mem_ack,
    output logic [31:0] Mem_addr,
    output logic        Mem_rd,
    output logic [31:0] Instr,
    output logic        Instr_valid,
    output logic [31:0] PC,
    output logic        Busy,
    output logic        Fetch_err
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_d;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   addr_d;
    logic [XLEN-1:0]   instr_d;
    logic              valid_d;
    logic              rd_d;
    logic              busy_d;
    logic              err_d;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   imm_sh;
    logic [XLEN-1:0]   next_pc;

    // Shifting in XLEN bits drops Immed[31:30]; all sums wrap modulo 2^32.
    assign imm_sh   = Immed << 2;
    assign pc_plus4 = PC + XLEN'(4);
    assign next_pc  = PC_sel ? (pc_plus4 + imm_sh) : pc_plus4;

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            PC          <= RESET_PC;
            Mem_addr    <= '0;
            Mem_rd      <= 1'b0;
            Instr       <= '0;
            Instr_valid <= 1'b0;
            Busy        <= 1'b0;
            Fetch_err   <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_d;
            PC          <= pc_d;
            Mem_addr    <= addr_d;
            Mem_rd      <= rd_d;
            Instr       <= instr_d;
            Instr_valid <= valid_d;
            Busy        <= busy_d;
            Fetch_err   <= err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next = state;
        cnt_d      = cnt;
        pc_d       = PC;
        addr_d     = Mem_addr;
        instr_d    = Instr;
        valid_d    = Instr_valid;
        rd_d       = 1'b0;
        err_d      = 1'b0;

        unique case (state)
            IDLE: begin
                if (PC_LdEn) begin
                    pc_d = next_pc;
                end
                // The fetch address is the PC before any same-cycle load.
                if (Fetch_req) begin
                    addr_d     = PC;
                    valid_d    = 1'b0;
                    cnt_d      = '0;
                    rd_d       = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (Mem_ack) begin
                    instr_d    = Mem_data;
                    valid_d    = 1'b1;
                    state_next = DONE;
                end else if (cnt == LAST_CNT) begin
                    err_d      = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                    rd_d  = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_d = (state_next != IDLE);
    end

endmodule

// File: tb/tb_ifstage_fetch.sv
// Directed bench for ifstage_fetch: fetch handshake, PC arithmetic, timeout,
// ignored inputs during WAIT/IDLE, and reset mid-fetch.
module tb_ifstage_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Fetch_req;
    logic        PC_LdEn;
    logic        PC_sel;
    logic [31:0] Immed;
    logic [31:0] Mem_data;
    logic        Mem_ack;
    logic [31:0] Mem_addr;
    logic        Mem_rd;
    logic [31:0] Instr;
    logic        Instr_valid;
    logic [31:0] PC;
    logic        Busy;
    logic        Fetch_err;

    int checks = 0;
    int errors = 0;

    ifstage_fetch #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (4)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Fetch_req   (Fetch_req),
        .PC_LdEn     (PC_LdEn),
        .PC_sel      (PC_sel),
        .Immed       (Immed),
        .Mem_data    (Mem_data),
        .Mem_ack     (Mem_ack),
        .Mem_addr    (Mem_addr),
        .Mem_rd      (Mem_rd),
        .Instr       (Instr),
        .Instr_valid (Instr_valid),
        .PC          (PC),
        .Busy        (Busy),
        .Fetch_err   (Fetch_err)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic rd, input logic busy,
                           input logic valid, input logic err);
        chk({tag, ".rd"},    32'(Mem_rd),      32'(rd));
        chk({tag, ".busy"},  32'(Busy),        32'(busy));
        chk({tag, ".valid"}, 32'(Instr_valid), 32'(valid));
        chk({tag, ".err"},   32'(Fetch_err),   32'(err));
    endtask

    initial begin
        Reset = 1'b1; Fetch_req = 1'b0; PC_LdEn = 1'b0; PC_sel = 1'b0;
        Immed = '0; Mem_data = '0; Mem_ack = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        chk("rst.pc", PC, 32'h0);
        chk("rst.addr", Mem_addr, 32'h0);
        chk("rst.instr", Instr, 32'h0);
        chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic fetch, ack in the third WAIT cycle
        Fetch_req = 1'b1;
        tick();
        Fetch_req = 1'b0;
        chk("f1.addr", Mem_addr, 32'h0);
        chk_ctl("f1.w1", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_ctl("f1.w2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_ctl("f1.w3", 1'b1, 1'b1, 1'b0, 1'b0);
        Mem_ack = 1'b1; Mem_data = 32'h2001_0005;
        tick();
        Mem_ack = 1'b0; Mem_data = '0;
        chk("f1.instr", Instr, 32'h2001_0005);
        chk_ctl("f1.done", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_ctl("f1.idle", 1'b0, 1'b0, 1'b1, 1'b0);

        // PC arithmetic: 0 -> 0x100 -> 0x110 -> 0xFFFFFFFC -> 0 -> 0x40
        PC_LdEn = 1'b1; PC_sel = 1'b1; Immed = 32'h0000_003F;
        tick();
        chk("pc.0x100", PC, 32'h0000_0100);
        Immed = 32'h0000_0003;
        tick();
        chk("pc.0x110", PC, 32'h0000_0110);
        Immed = 32'hFFFF_FFBA;
        tick();
        chk("pc.topbits", PC, 32'hFFFF_FFFC);
        PC_sel = 1'b0;
        tick();
        chk("pc.wrap", PC, 32'h0000_0000);
        PC_sel = 1'b1; Immed = 32'h0000_000F;
        tick();
        chk("pc.0x40", PC, 32'h0000_0040);

        // Fetch and PC load in the same cycle
        PC_sel = 1'b0; Fetch_req = 1'b1;
        tick();
        PC_LdEn = 1'b0; Fetch_req = 1'b0;
        chk("same.addr", Mem_addr, 32'h0000_0040);
        chk("same.pc", PC, 32'h0000_0044);
        chk_ctl("same.w1", 1'b1, 1'b1, 1'b0, 1'b0);

        // Inputs ignored during WAIT, then timeout with MAX_WAIT=4
        PC_LdEn = 1'b1; Fetch_req = 1'b1; PC_sel = 1'b1; Immed = 32'h0000_0100;
        tick();
        PC_LdEn = 1'b0; Fetch_req = 1'b0;
        chk("wait.pc", PC, 32'h0000_0044);
        chk("wait.addr", Mem_addr, 32'h0000_0040);
        chk_ctl("to.w2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_ctl("to.w3", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_ctl("to.w4", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_ctl("to.err", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("to.instr", Instr, 32'h2001_0005);
        tick();
        chk_ctl("to.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Stray ack in IDLE is ignored
        Mem_ack = 1'b1; Mem_data = 32'hDEAD_BEEF;
        tick();
        Mem_ack = 1'b0; Mem_data = '0;
        chk("stray.instr", Instr, 32'h2001_0005);
        chk("stray.pc", PC, 32'h0000_0044);
        chk_ctl("stray", 1'b0, 1'b0, 1'b0, 1'b0);

        // Ack on the final WAIT cycle beats the timeout
        Fetch_req = 1'b1;
        tick();
        Fetch_req = 1'b0;
        chk("late.addr", Mem_addr, 32'h0000_0044);
        tick(); tick(); tick();
        chk_ctl("late.w4", 1'b1, 1'b1, 1'b0, 1'b0);
        Mem_ack = 1'b1; Mem_data = 32'h1234_5678;
        tick();
        Mem_ack = 1'b0; Mem_data = '0;
        chk("late.instr", Instr, 32'h1234_5678);
        chk_ctl("late.done", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_ctl("late.idle", 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset in the second WAIT cycle, then a late ack
        PC_LdEn = 1'b1; PC_sel = 1'b1; Immed = 32'h0000_000E;
        tick();
        PC_LdEn = 1'b0;
        chk("r.pc80", PC, 32'h0000_0080);
        Fetch_req = 1'b1;
        tick();
        Fetch_req = 1'b0;
        chk("r.addr", Mem_addr, 32'h0000_0080);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("r.pc", PC, 32'h0);
        chk("r.addr0", Mem_addr, 32'h0);
        chk("r.instr", Instr, 32'h0);
        chk_ctl("r.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        Mem_ack = 1'b1; Mem_data = 32'hCAFE_F00D;
        tick();
        Mem_ack = 1'b0; Mem_data = '0;
        chk("r.ack.instr", Instr, 32'h0);
        chk("r.ack.pc", PC, 32'h0);
        chk_ctl("r.ack", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
